// File: rtl/cpu_types_pkg.sv
// Shared types for the 5-stage core: pipeline-control FSM state and per-latch control.
package cpu_types_pkg;

   typedef enum logic [1:0] {RUN, DWAIT, HALTED} pipe_state_t;

   typedef struct packed {
      logic en;
      logic flush;
   } stage_ctrl_t;

   localparam stage_ctrl_t SC_HOLD  = '{en: 1'b0, flush: 1'b0};
   localparam stage_ctrl_t SC_ADV   = '{en: 1'b1, flush: 1'b0};
   localparam stage_ctrl_t SC_FLUSH = '{en: 1'b0, flush: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge CLK) begin
      if (RST)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline latch enable/flush generation, dcache wait and halt sequencing for the 5-stage core.
module pipeline_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             lwForwardA,
   input  logic             lwForwardB,
   input  logic             jump_id,
   input  logic             branch_mem,
   input  logic             dREN_mem,
   input  logic             dWEN_mem,
   input  logic             dhit,
   input  logic             ihit,
   input  logic             halt_wb,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             exmem_flush,
   output logic             memwb_en,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   pipe_state_t state, nxt_state;
   stage_ctrl_t ifid_c, idex_c, exmem_c;
   logic        pc_c, memwb_c;
   logic        lu, dmem, fetch_ok, run, br_take, jmp_take;
   logic        ihit_pend;

   assign lu       = lwForwardA | lwForwardB;
   assign dmem     = dREN_mem | dWEN_mem;
   assign fetch_ok = ihit | ihit_pend;

   always_comb begin
      nxt_state = state;
      pc_c      = 1'b0;
      memwb_c   = 1'b0;
      ifid_c    = SC_HOLD;
      idex_c    = SC_HOLD;
      exmem_c   = SC_HOLD;
      br_take   = 1'b0;
      jmp_take  = 1'b0;
      run       = 1'b0;
      case (state)
         RUN:     run = 1'b1;
         DWAIT:   begin
                     run = dhit;
                     if (dhit) nxt_state = RUN;
                  end
         default: run = 1'b0;
      endcase
      // In DWAIT run implies dhit, so the dmem-stall arm can never re-enter DWAIT there.
      if (run) begin
         if (halt_wb) begin
            nxt_state = HALTED;
         end else if (dmem && !dhit) begin
            nxt_state = DWAIT;
         end else if (branch_mem) begin
            pc_c    = 1'b1;
            ifid_c  = SC_FLUSH;
            idex_c  = SC_FLUSH;
            exmem_c = SC_FLUSH;
            memwb_c = 1'b1;
            br_take = 1'b1;
         end else if (lu) begin
            idex_c  = SC_FLUSH;
            exmem_c = SC_ADV;
            memwb_c = 1'b1;
         end else if (jump_id) begin
            pc_c     = 1'b1;
            ifid_c   = SC_FLUSH;
            idex_c   = SC_ADV;
            exmem_c  = SC_ADV;
            memwb_c  = 1'b1;
            jmp_take = 1'b1;
         end else if (!fetch_ok) begin
            ifid_c  = SC_FLUSH;
            idex_c  = SC_ADV;
            exmem_c = SC_ADV;
            memwb_c = 1'b1;
         end else begin
            pc_c    = 1'b1;
            ifid_c  = SC_ADV;
            idex_c  = SC_ADV;
            exmem_c = SC_ADV;
            memwb_c = 1'b1;
         end
      end
      if (RST) begin
         nxt_state = RUN;
         pc_c      = 1'b0;
         memwb_c   = 1'b0;
         ifid_c    = SC_FLUSH;
         idex_c    = SC_FLUSH;
         exmem_c   = SC_FLUSH;
         br_take   = 1'b0;
         jmp_take  = 1'b0;
      end
   end

   // A flush always wins over the enable on the same latch.
   assign pc_en       = pc_c;
   assign ifid_en     = ifid_c.en  & ~ifid_c.flush;
   assign ifid_flush  = ifid_c.flush;
   assign idex_en     = idex_c.en  & ~idex_c.flush;
   assign idex_flush  = idex_c.flush;
   assign exmem_en    = exmem_c.en & ~exmem_c.flush;
   assign exmem_flush = exmem_c.flush;
   assign memwb_en    = memwb_c;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= RUN;
         halted    <= 1'b0;
         ihit_pend <= 1'b0;
      end else begin
         state  <= nxt_state;
         halted <= (nxt_state == HALTED);
         // Remember an icache return that arrived while the PC was frozen.
         if (pc_c || br_take || jmp_take)
            ihit_pend <= 1'b0;
         else if (ihit)
            ihit_pend <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (!pc_c && (state != HALTED)),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (br_take),
      .count (flush_cnt)
   );

endmodule
